// File: rtl/cu_pkg.sv
// ============================================================================
//  Module      : cu_pkg
//  Description : Shared opcodes, FSM state encoding and bus-select codes for
//                the 16-bit RISC control unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cu_pkg;

    localparam int data_width      = 16;
    localparam int RF_W_Addr_Width = 4;
    localparam int sel_bus_1_size  = 5;
    localparam int sel_bus_2_size  = 2;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_NOT  = 4'h4;
    localparam logic [3:0] OP_LDI  = 4'h5;
    localparam logic [3:0] OP_RD   = 4'h6;
    localparam logic [3:0] OP_WR   = 4'h7;
    localparam logic [3:0] OP_BR   = 4'h8;
    localparam logic [3:0] OP_BRZ  = 4'h9;
    localparam logic [3:0] OP_BNZ  = 4'hA;
    localparam logic [3:0] OP_BIZ  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_MOV  = 4'hD;
    localparam logic [3:0] OP_ILL  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FET1 = 3'd1,
        S_FET2 = 3'd2,
        S_DEC  = 3'd3,
        S_EX1  = 3'd4,
        S_EX2  = 3'd5,
        S_HALT = 3'd6
    } state_t;

    localparam logic [sel_bus_1_size-1:0] SEL1_PC   = 5'd16;
    localparam logic [sel_bus_1_size-1:0] SEL1_IMM  = 5'd17;
    localparam logic [sel_bus_2_size-1:0] SEL2_ALU  = 2'd0;
    localparam logic [sel_bus_2_size-1:0] SEL2_BUS1 = 2'd1;
    localparam logic [sel_bus_2_size-1:0] SEL2_MEM  = 2'd2;

    // ALU-class opcodes write Rd from the ALU and update Reg_Z
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_NOT);
    endfunction

    // Opcodes that need the single execute state after decode
    function automatic logic needs_ex1(input logic [3:0] op);
        return is_alu_op(op) || (op == OP_RD) || (op == OP_WR) || (op == OP_BIZ);
    endfunction

endpackage

`default_nettype wire

// File: rtl/control_unit_if.sv
// ============================================================================
//  Module      : control_unit_if
//  Description : Control bundle between the control unit (master) and the
//                processing unit (slave). The illegal_op strobe exists only
//                when CU_ILLEGAL_TRAP_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface control_unit_if;
    import cu_pkg::*;

    logic [data_width-1:0]      instruction;
    logic                       RF_Ry_Zero;
    logic                       alu_zero;

    logic [RF_W_Addr_Width-1:0] RF_W_Addr;
    logic                       RF_W_En;
    logic                       PC_Ld;
    logic                       PC_Inc;
    logic                       sel_PC_Offset_Update;
    logic                       IR_Ld;
    logic                       Reg_Y_Ld;
    logic                       Reg_A_Ld;
    logic                       Reg_Z_Ld;
    logic                       Sign_Ext_Flag;
    logic [sel_bus_1_size-1:0]  Sel_Bus_1_MUX;
    logic [sel_bus_2_size-1:0]  Sel_Bus_2_MUX;
    logic                       mem_write;
    logic                       halted;
`ifdef CU_ILLEGAL_TRAP_EN
    logic                       illegal_op;
`endif

    modport master (
        input  instruction, RF_Ry_Zero, alu_zero,
        output RF_W_Addr, RF_W_En, PC_Ld, PC_Inc, sel_PC_Offset_Update, IR_Ld,
               Reg_Y_Ld, Reg_A_Ld, Reg_Z_Ld, Sign_Ext_Flag, Sel_Bus_1_MUX,
               Sel_Bus_2_MUX, mem_write, halted
`ifdef CU_ILLEGAL_TRAP_EN
        , illegal_op
`endif
    );

    modport slave (
        output instruction, RF_Ry_Zero, alu_zero,
        input  RF_W_Addr, RF_W_En, PC_Ld, PC_Inc, sel_PC_Offset_Update, IR_Ld,
               Reg_Y_Ld, Reg_A_Ld, Reg_Z_Ld, Sign_Ext_Flag, Sel_Bus_1_MUX,
               Sel_Bus_2_MUX, mem_write, halted
`ifdef CU_ILLEGAL_TRAP_EN
        , illegal_op
`endif
    );

endinterface

`default_nettype wire

// File: rtl/control_unit_decode.sv
// ============================================================================
//  Module      : control_unit_decode
//  Description : Moore output decode: FSM state, IR fields and flags to every
//                datapath control. Honours CU_ILLEGAL_TRAP_EN for illegal_op.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_unit_decode
    import cu_pkg::*;
(
    input  state_t         state,
    control_unit_if.master cu
);

    logic [3:0] op;
    logic [3:0] rd;
    logic [3:0] rs;

    assign op = cu.instruction[15:12];
    assign rd = cu.instruction[11:8];
    assign rs = cu.instruction[7:4];

    // Every control defaults low; each state raises only what it needs
    always_comb begin
        cu.RF_W_Addr            = '0;
        cu.RF_W_En              = 1'b0;
        cu.PC_Ld                = 1'b0;
        cu.PC_Inc               = 1'b0;
        cu.sel_PC_Offset_Update = 1'b0;
        cu.IR_Ld                = 1'b0;
        cu.Reg_Y_Ld             = 1'b0;
        cu.Reg_A_Ld             = 1'b0;
        cu.Reg_Z_Ld             = 1'b0;
        cu.Sign_Ext_Flag        = 1'b0;
        cu.Sel_Bus_1_MUX        = '0;
        cu.Sel_Bus_2_MUX        = '0;
        cu.mem_write            = 1'b0;
        cu.halted               = 1'b0;
`ifdef CU_ILLEGAL_TRAP_EN
        cu.illegal_op           = 1'b0;
`endif
        case (state)
            S_FET1: begin
                cu.Sel_Bus_1_MUX = SEL1_PC;
                cu.Sel_Bus_2_MUX = SEL2_BUS1;
                cu.Reg_A_Ld      = 1'b1;
            end
            S_FET2: begin
                cu.Sel_Bus_2_MUX = SEL2_MEM;
                cu.IR_Ld         = 1'b1;
                cu.PC_Inc        = 1'b1;
            end
            S_DEC: begin
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_NOT: begin
                        cu.Sel_Bus_1_MUX = {1'b0, rs};
                        cu.Sel_Bus_2_MUX = SEL2_BUS1;
                        cu.Reg_Y_Ld      = 1'b1;
                    end
                    OP_LDI: begin
                        cu.Sel_Bus_1_MUX = SEL1_IMM;
                        cu.Sign_Ext_Flag = 1'b1;
                        cu.Sel_Bus_2_MUX = SEL2_BUS1;
                        cu.RF_W_En       = 1'b1;
                        cu.RF_W_Addr     = rd;
                    end
                    OP_MOV: begin
                        cu.Sel_Bus_1_MUX = {1'b0, rs};
                        cu.Sel_Bus_2_MUX = SEL2_BUS1;
                        cu.RF_W_En       = 1'b1;
                        cu.RF_W_Addr     = rd;
                    end
                    OP_RD: begin
                        cu.Sel_Bus_1_MUX = {1'b0, rs};
                        cu.Sel_Bus_2_MUX = SEL2_BUS1;
                        cu.Reg_A_Ld      = 1'b1;
                    end
                    OP_WR: begin
                        cu.Sel_Bus_1_MUX = {1'b0, rd};
                        cu.Sel_Bus_2_MUX = SEL2_BUS1;
                        cu.Reg_A_Ld      = 1'b1;
                    end
                    OP_BR:  cu.PC_Ld = 1'b1;
                    OP_BRZ: cu.PC_Ld = cu.alu_zero;
                    OP_BNZ: cu.PC_Ld = ~cu.alu_zero;
                    OP_BIZ: begin
                        cu.Sel_Bus_1_MUX = {1'b0, rd};
                        cu.Sel_Bus_2_MUX = SEL2_BUS1;
                        cu.Reg_Y_Ld      = 1'b1;
                    end
                    OP_JMP: begin
                        cu.Sel_Bus_1_MUX        = {1'b0, rd};
                        cu.Sel_Bus_2_MUX        = SEL2_BUS1;
                        cu.sel_PC_Offset_Update = 1'b1;
                        cu.PC_Ld                = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_EX1: begin
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_NOT: begin
                        cu.Sel_Bus_1_MUX = {1'b0, rd};
                        cu.Sel_Bus_2_MUX = SEL2_ALU;
                        cu.RF_W_En       = 1'b1;
                        cu.RF_W_Addr     = rd;
                        cu.Reg_Z_Ld      = 1'b1;
                    end
                    OP_RD: begin
                        cu.Sel_Bus_2_MUX = SEL2_MEM;
                        cu.RF_W_En       = 1'b1;
                        cu.RF_W_Addr     = rd;
                    end
                    OP_WR: begin
                        cu.Sel_Bus_1_MUX = {1'b0, rs};
                        cu.Sel_Bus_2_MUX = SEL2_BUS1;
                        cu.mem_write     = 1'b1;
                    end
                    OP_BIZ: cu.PC_Ld = cu.RF_Ry_Zero;
                    default: ;
                endcase
            end
`ifdef CU_ILLEGAL_TRAP_EN
            S_EX2: cu.illegal_op = 1'b1;
`endif
            S_HALT: cu.halted = 1'b1;
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/control_unit.sv
// ============================================================================
//  Module      : control_unit
//  Description : Multi-cycle FSM controller for the 16-bit RISC core. Holds
//                the state register and sequencing; output decode lives in
//                control_unit_decode. Define CU_ILLEGAL_TRAP_EN to trap
//                opcode E through S_EX2 into S_HALT (otherwise it is a NOP).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_unit
    import cu_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    control_unit_if.master cu
);

    state_t     state;
    logic [3:0] op;

    assign op = cu.instruction[15:12];

    // State register with sequencing; rst low forces S_IDLE immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: state <= S_FET1;
                S_FET1: state <= S_FET2;
                S_FET2: state <= S_DEC;
                S_DEC: begin
                    if (needs_ex1(op))
                        state <= S_EX1;
                    else if (op == OP_HALT)
                        state <= S_HALT;
`ifdef CU_ILLEGAL_TRAP_EN
                    else if (op == OP_ILL)
                        state <= S_EX2;
`endif
                    else
                        state <= S_FET1;
                end
                S_EX1: state <= S_FET1;
`ifdef CU_ILLEGAL_TRAP_EN
                S_EX2: state <= S_HALT;
`else
                S_EX2: state <= S_FET1;
`endif
                S_HALT: state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

    control_unit_decode u_decode (
        .state (state),
        .cu    (cu)
    );

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// ============================================================================
//  Module      : tb_control_unit
//  Description : Directed testbench for control_unit with hand-computed
//                control vectors per state. Follows CU_ILLEGAL_TRAP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_unit;
    import cu_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    control_unit_if cu_bus ();

    control_unit dut (
        .clk (clk),
        .rst (rst),
        .cu  (cu_bus)
    );

    int checks = 0;
    int errors = 0;

    // Packed view of every control:
    // [21:18] addr, 17 wen, 16 pcld, 15 pcinc, 14 selpc, 13 irld, 12 yld,
    // 11 ald, 10 zld, 9 sext, [8:4] sel1, [3:2] sel2, 1 memw, 0 halted
    logic [21:0] outs;
    assign outs = {cu_bus.RF_W_Addr, cu_bus.RF_W_En, cu_bus.PC_Ld, cu_bus.PC_Inc,
                   cu_bus.sel_PC_Offset_Update, cu_bus.IR_Ld, cu_bus.Reg_Y_Ld,
                   cu_bus.Reg_A_Ld, cu_bus.Reg_Z_Ld, cu_bus.Sign_Ext_Flag,
                   cu_bus.Sel_Bus_1_MUX, cu_bus.Sel_Bus_2_MUX, cu_bus.mem_write,
                   cu_bus.halted};

    localparam logic [21:0] PCLD  = 22'd1 << 16;
    localparam logic [21:0] PCINC = 22'd1 << 15;
    localparam logic [21:0] SELPC = 22'd1 << 14;
    localparam logic [21:0] IRLD  = 22'd1 << 13;
    localparam logic [21:0] YLD   = 22'd1 << 12;
    localparam logic [21:0] ALD   = 22'd1 << 11;
    localparam logic [21:0] ZLD   = 22'd1 << 10;
    localparam logic [21:0] SEXT  = 22'd1 << 9;
    localparam logic [21:0] MEMW  = 22'd1 << 1;
    localparam logic [21:0] HALTB = 22'd1;

    function automatic logic [21:0] sel(input logic [4:0] s1, input logic [1:0] s2);
        return {13'd0, s1, s2, 2'b00};
    endfunction

    function automatic logic [21:0] wr(input logic [3:0] a);
        return {a, 1'b1, 17'd0};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts in S_FET1, ends in the next instruction's S_FET1 (or S_HALT)
    task automatic run_instr(input string tag, input logic [15:0] ir,
                             input logic [21:0] exp_dec, input bit has_ex1,
                             input logic [21:0] exp_ex1);
        check({tag, ":fet1"}, {10'd0, outs}, {10'd0, sel(5'd16, 2'd1) | ALD});
        step();
        check({tag, ":fet2"}, {10'd0, outs}, {10'd0, sel(5'd0, 2'd2) | IRLD | PCINC});
        cu_bus.instruction = ir;
        step();
        check({tag, ":dec"}, {10'd0, outs}, {10'd0, exp_dec});
        if (has_ex1) begin
            step();
            check({tag, ":ex1"}, {10'd0, outs}, {10'd0, exp_ex1});
        end
        step();
    endtask

    // Asynchronous reset pulse between edges, release on a falling edge
    task automatic rst_pulse(input string tag);
        #2 rst = 1'b0;
        #1 check({tag, ":rst_low"}, {10'd0, outs}, 32'd0);
        @(negedge clk) rst = 1'b1;
        #1 check({tag, ":idle"}, {10'd0, outs}, 32'd0);
        step();
    endtask

    initial begin
        rst                = 1'b0;
        cu_bus.instruction = 16'h0000;
        cu_bus.alu_zero    = 1'b0;
        cu_bus.RF_Ry_Zero  = 1'b0;
        step();
        step();
        check("reset", {10'd0, outs}, 32'd0);
        @(negedge clk) rst = 1'b1;
        #1 check("idle", {10'd0, outs}, 32'd0);
        step();

        run_instr("add",    16'h1320, sel(5'd2, 2'd1) | YLD, 1'b1, sel(5'd3, 2'd0) | wr(4'd3) | ZLD);
        cu_bus.alu_zero = 1'b0;
        run_instr("brz_nt", 16'h95FF, 22'd0, 1'b0, 22'd0);
        cu_bus.alu_zero = 1'b1;
        run_instr("brz_t",  16'h95FF, PCLD, 1'b0, 22'd0);
        run_instr("bnz_nt", 16'hA010, 22'd0, 1'b0, 22'd0);
        cu_bus.alu_zero = 1'b0;
        run_instr("bnz_t",  16'hA010, PCLD, 1'b0, 22'd0);
        run_instr("br",     16'h8003, PCLD, 1'b0, 22'd0);
        run_instr("wr",     16'h7410, sel(5'd4, 2'd1) | ALD, 1'b1, sel(5'd1, 2'd1) | MEMW);
        run_instr("ldi",    16'h53FE, sel(5'd17, 2'd1) | SEXT | wr(4'd3), 1'b0, 22'd0);
        run_instr("mov",    16'hD560, sel(5'd6, 2'd1) | wr(4'd5), 1'b0, 22'd0);
        run_instr("rd",     16'h6270, sel(5'd7, 2'd1) | ALD, 1'b1, sel(5'd0, 2'd2) | wr(4'd2));
        run_instr("not",    16'h4180, sel(5'd8, 2'd1) | YLD, 1'b1, sel(5'd1, 2'd0) | wr(4'd1) | ZLD);
        run_instr("sub",    16'h2AB0, sel(5'd11, 2'd1) | YLD, 1'b1, sel(5'd10, 2'd0) | wr(4'd10) | ZLD);
        cu_bus.RF_Ry_Zero = 1'b1;
        run_instr("biz_t",  16'hB900, sel(5'd9, 2'd1) | YLD, 1'b1, PCLD);
        cu_bus.RF_Ry_Zero = 1'b0;
        run_instr("biz_nt", 16'hB900, sel(5'd9, 2'd1) | YLD, 1'b1, 22'd0);
        run_instr("jmp",    16'hC700, sel(5'd7, 2'd1) | SELPC | PCLD, 1'b0, 22'd0);
        run_instr("nop",    16'h0000, 22'd0, 1'b0, 22'd0);

        // Reset in the middle of an ADD decode
        step();
        cu_bus.instruction = 16'h1320;
        step();
        rst_pulse("mid_instr");

`ifdef CU_ILLEGAL_TRAP_EN
        check("ill:fet1", {10'd0, outs}, {10'd0, sel(5'd16, 2'd1) | ALD});
        step();
        cu_bus.instruction = 16'hE000;
        step();
        check("ill:dec", {10'd0, outs}, 32'd0);
        step();
        check("ill:ex2_flag", {31'd0, cu_bus.illegal_op}, 32'd1);
        check("ill:ex2_outs", {10'd0, outs}, 32'd0);
        step();
        check("ill:flag_clr", {31'd0, cu_bus.illegal_op}, 32'd0);
`else
        run_instr("ill_nop", 16'hE000, 22'd0, 1'b0, 22'd0);
        run_instr("halt",    16'hF000, 22'd0, 1'b0, 22'd0);
`endif
        for (int k = 0; k < 4; k++) begin
            check("halted", {10'd0, outs}, {10'd0, HALTB});
            step();
        end
        rst_pulse("halt_rst");
        run_instr("restart", 16'h0000, 22'd0, 1'b0, 22'd0);
        check("refetch", {10'd0, outs}, {10'd0, sel(5'd16, 2'd1) | ALD});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
